// File: rtl/layer_dense_engine.sv
// Fully connected layer: binary inputs select signed weights and accumulate with saturation, then bias and activation.
// Latency IN_COUNT+2 cycles from start to done; start is only taken while idle and is ignored (not queued) while busy.
module layer_dense_engine #(
    parameter int    IN_COUNT     = 256,
    parameter int    OUT_COUNT    = 20,
    parameter int    WEIGHT_WIDTH = 8,
    parameter int    BIAS_WIDTH   = 8,
    parameter int    ACC_WIDTH    = 16,
    parameter int    LEAKY_SHIFT  = 3,
    parameter string WEIGHT_FILE  = "weight.mem",
    parameter string BIAS_FILE    = "bias.mem"
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [IN_COUNT-1:0]            layer_input,
    input  logic [1:0]                     act_mode,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           sat_flag,
    output logic [OUT_COUNT*ACC_WIDTH-1:0] layer_output
);

    localparam int IDX_W = $clog2(IN_COUNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_COUNT - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_BIAS, ST_ACT} state_t;

    // Row i holds the weights of input i for every neuron, neuron 0 in the LSBs.
    logic [OUT_COUNT*WEIGHT_WIDTH-1:0] weight_mem [IN_COUNT];
    logic [BIAS_WIDTH-1:0]             bias_mem   [OUT_COUNT];

    state_t                        state_q, state_d;
    logic [IN_COUNT-1:0]           in_q, in_d;
    logic [1:0]                    mode_q, mode_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]   acc_q [OUT_COUNT];
    logic signed [ACC_WIDTH-1:0]   acc_d [OUT_COUNT];
    logic [OUT_COUNT*ACC_WIDTH-1:0] out_q, out_d;
    logic                          done_q, done_d;
    logic                          sat_q, sat_d;

    logic [OUT_COUNT*WEIGHT_WIDTH-1:0] w_row;
    logic [ACC_WIDTH:0]                mac_res  [OUT_COUNT];
    logic [ACC_WIDTH:0]                bias_res [OUT_COUNT];
    logic [ACC_WIDTH-1:0]              act_res  [OUT_COUNT];

    // Returns {overflow, clamped sum}.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                   input logic signed [ACC_WIDTH-1:0] b);
        logic signed [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return {1'b1, (s[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
        return {1'b0, s[ACC_WIDTH-1:0]};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] activate(input logic signed [ACC_WIDTH-1:0] a,
                                                      input logic [1:0] mode);
        case (mode)
            2'd0:    return a[ACC_WIDTH-1] ? (a >>> LEAKY_SHIFT) : a;
            2'd1:    return a[ACC_WIDTH-1] ? '0 : a;
            default: return a;
        endcase
    endfunction

    assign w_row = weight_mem[idx_q];

    for (genvar n = 0; n < OUT_COUNT; n++) begin : g_neuron
        logic signed [WEIGHT_WIDTH-1:0] w_n;
        logic signed [BIAS_WIDTH-1:0]   b_n;
        assign w_n         = w_row[n*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign b_n         = bias_mem[n];
        assign mac_res[n]  = sat_add(acc_q[n], ACC_WIDTH'(w_n));
        assign bias_res[n] = sat_add(acc_q[n], ACC_WIDTH'(b_n));
        assign act_res[n]  = activate(acc_q[n], mode_q);
    end

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        out_d   = out_q;
        done_d  = 1'b0;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    in_d   = layer_input;
                    mode_d = act_mode;
                    idx_d  = '0;
                    sat_d  = 1'b0;
                    for (int n = 0; n < OUT_COUNT; n++) acc_d[n] = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (in_q[idx_q]) begin
                    for (int n = 0; n < OUT_COUNT; n++) begin
                        acc_d[n] = mac_res[n][ACC_WIDTH-1:0];
                        sat_d    = sat_d | mac_res[n][ACC_WIDTH];
                    end
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_BIAS;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_BIAS: begin
                for (int n = 0; n < OUT_COUNT; n++) begin
                    acc_d[n] = bias_res[n][ACC_WIDTH-1:0];
                    sat_d    = sat_d | bias_res[n][ACC_WIDTH];
                end
                state_d = ST_ACT;
            end
            ST_ACT: begin
                for (int n = 0; n < OUT_COUNT; n++) out_d[n*ACC_WIDTH +: ACC_WIDTH] = act_res[n];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            in_q    <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
            for (int n = 0; n < OUT_COUNT; n++) acc_q[n] <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            for (int n = 0; n < OUT_COUNT; n++) acc_q[n] <= acc_d[n];
            out_q   <= out_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign sat_flag     = sat_q;
    assign layer_output = out_q;

endmodule

// File: tb/tb_layer_dense_engine.sv
// Self-checking bench for layer_dense_engine in a 4-input, 2-neuron, 8-bit configuration.
module tb_layer_dense_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  layer_input;
    logic [1:0]  act_mode;
    logic        start;
    logic        busy, done, sat_flag;
    logic [15:0] layer_output;

    int tests = 0;
    int fails = 0;
    int w_ref [4][2];
    int b_ref [2];

    layer_dense_engine #(
        .IN_COUNT(4), .OUT_COUNT(2), .WEIGHT_WIDTH(8), .BIAS_WIDTH(8),
        .ACC_WIDTH(8), .LEAKY_SHIFT(3), .WEIGHT_FILE(""), .BIAS_FILE("")
    ) dut (
        .clk(clk), .reset(reset), .layer_input(layer_input), .act_mode(act_mode),
        .start(start), .busy(busy), .done(done), .sat_flag(sat_flag),
        .layer_output(layer_output)
    );

    always #5 clk = ~clk;

    task automatic load_params();
        for (int i = 0; i < 4; i++) dut.weight_mem[i] = {8'(w_ref[i][1]), 8'(w_ref[i][0])};
        for (int n = 0; n < 2; n++) dut.bias_mem[n] = 8'(b_ref[n]);
    endtask

    task automatic set_spec_params();
        w_ref[0] = '{10, -3};
        w_ref[1] = '{20, -4};
        w_ref[2] = '{30, -5};
        w_ref[3] = '{40, -6};
        b_ref    = '{1, -2};
        load_params();
    endtask

    function automatic int clamp(input int v, inout logic sat);
        if (v > 127) begin sat = 1'b1; return 127; end
        if (v < -128) begin sat = 1'b1; return -128; end
        return v;
    endfunction

    // Reference: integer sums clamped after every add, then the activation on plain integers.
    function automatic void model(input logic [3:0] vec, input logic [1:0] mode,
                                  output logic [15:0] out, output logic sat);
        int acc, a;
        sat = 1'b0;
        out = '0;
        for (int n = 0; n < 2; n++) begin
            acc = 0;
            for (int i = 0; i < 4; i++)
                if (vec[i]) acc = clamp(acc + w_ref[i][n], sat);
            acc = clamp(acc + b_ref[n], sat);
            if (acc >= 0 || mode >= 2) a = acc;
            else if (mode == 1) a = 0;
            else a = -((-acc + 7) / 8);
            out[n*8 +: 8] = 8'(a);
        end
    endfunction

    task automatic run_layer(input logic [3:0] vec, input logic [1:0] mode,
                             output int lat, output logic [15:0] out, output logic sat);
        @(negedge clk);
        layer_input = vec;
        act_mode    = mode;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        out = '0;
        sat = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                lat = c;
                out = layer_output;
                sat = sat_flag;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (lat < 0) begin
            fails++;
            $display("FAIL run_timeout: no done within 40 cycles (vec=%b mode=%0d)", vec, mode);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; layer_input = '0; act_mode = '0;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
        tests++; if (layer_output !== 16'h0) begin fails++; $display("FAIL reset_out: got %h want 0000", layer_output); end
        reset = 1'b0;
        set_spec_params();
        @(negedge clk);
    endtask

    task automatic test_basic_leaky();
        logic [15:0] exp_out; logic exp_sat;
        int dones = 0, done_at = -1, busy_bad = 0;
        model(4'b0101, 2'd0, exp_out, exp_sat);
        @(negedge clk);
        layer_input = 4'b0101; act_mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (busy !== (c <= 5)) busy_bad++;
            if (done) begin dones++; done_at = c; end
            if (c == 6) begin
                tests++;
                if (layer_output !== exp_out) begin fails++; $display("FAIL basic_out: got %h want %h", layer_output, exp_out); end
                tests++;
                if (layer_output !== {8'hFE, 8'd41}) begin fails++; $display("FAIL basic_out_const: got %h want fe29", layer_output); end
                tests++;
                if (sat_flag !== exp_sat) begin fails++; $display("FAIL basic_sat: got %b want %b", sat_flag, exp_sat); end
            end
            @(negedge clk);
        end
        tests++; if (busy_bad != 0) begin fails++; $display("FAIL basic_busy: %0d bad cycles want 0", busy_bad); end
        tests++; if (dones != 1 || done_at != 6) begin fails++; $display("FAIL basic_done: count %0d at %0d want 1 at 6", dones, done_at); end
    endtask

    task automatic test_modes();
        logic [15:0] out, exp_out; logic sat, exp_sat; int lat;
        logic [15:0] spec_out [3];
        spec_out = '{{8'd0, 8'd101}, {8'hEC, 8'd101}, {8'hEC, 8'd101}};
        for (int m = 1; m <= 3; m++) begin
            model(4'b1111, 2'(m), exp_out, exp_sat);
            run_layer(4'b1111, 2'(m), lat, out, sat);
            tests++; if (out !== exp_out) begin fails++; $display("FAIL mode%0d_out: got %h want %h", m, out, exp_out); end
            tests++; if (out !== spec_out[m-1]) begin fails++; $display("FAIL mode%0d_const: got %h want %h", m, out, spec_out[m-1]); end
            tests++; if (lat != 6) begin fails++; $display("FAIL mode%0d_latency: got %0d want 6", m, lat); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] out, exp_out; logic sat, exp_sat; int lat;
        w_ref[3][0] = 127;
        load_params();
        model(4'b1111, 2'd2, exp_out, exp_sat);
        run_layer(4'b1111, 2'd2, lat, out, sat);
        tests++; if (out[7:0] !== 8'd127 || out !== exp_out) begin fails++; $display("FAIL sat_pos_out: got %h want %h", out, exp_out); end
        tests++; if (sat !== 1'b1) begin fails++; $display("FAIL sat_pos_flag: got %b want 1", sat); end
        for (int i = 0; i < 4; i++) w_ref[i][1] = -100;
        load_params();
        model(4'b1111, 2'd2, exp_out, exp_sat);
        run_layer(4'b1111, 2'd2, lat, out, sat);
        tests++; if (out[15:8] !== 8'h80 || out !== exp_out) begin fails++; $display("FAIL sat_neg_out: got %h want %h", out, exp_out); end
        set_spec_params();
        model(4'b0101, 2'd0, exp_out, exp_sat);
        run_layer(4'b0101, 2'd0, lat, out, sat);
        tests++; if (sat !== 1'b0 || out !== exp_out) begin fails++; $display("FAIL sat_clear: got flag %b out %h want 0 %h", sat, out, exp_out); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] out2 = '0, exp_out; logic exp_sat;
        int dones = 0, first = -1, second = -1;
        model(4'b1111, 2'd2, exp_out, exp_sat);
        @(negedge clk);
        layer_input = 4'b0101; act_mode = 2'd0; start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            start = 1'b0;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first = c; start = 1'b1; layer_input = 4'b1111; act_mode = 2'd2;
                end else begin
                    second = c; out2 = layer_output;
                end
            end else if (c == 2 || c == 4) begin
                start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        tests++; if (dones != 2) begin fails++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
        tests++; if (second - first != 7) begin fails++; $display("FAIL b2b_gap: got %0d want 7", second - first); end
        tests++; if (out2 !== exp_out) begin fails++; $display("FAIL b2b_out: got %h want %h", out2, exp_out); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] out, exp_out; logic sat, exp_sat; int lat;
        @(negedge clk);
        layer_input = 4'b0101; act_mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset_ctrl: busy %b done %b want 0 0", busy, done); end
        tests++; if (layer_output !== 16'h0) begin fails++; $display("FAIL midreset_out: got %h want 0000", layer_output); end
        @(negedge clk);
        reset = 1'b0;
        model(4'b0101, 2'd0, exp_out, exp_sat);
        run_layer(4'b0101, 2'd0, lat, out, sat);
        tests++; if (out !== exp_out || lat != 6) begin fails++; $display("FAIL midreset_rerun: got %h lat %0d want %h lat 6", out, lat, exp_out); end
    endtask

    task automatic test_input_toggle();
        logic [15:0] exp_out, got = '0; logic exp_sat; logic [3:0] v; logic [1:0] m; int seen = 0;
        for (int r = 0; r < 3; r++) begin
            v = 4'($urandom_range(15));
            m = 2'($urandom_range(3));
            model(v, m, exp_out, exp_sat);
            @(negedge clk);
            layer_input = v; act_mode = m; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            seen = 0;
            for (int c = 0; c < 20 && seen == 0; c++) begin
                if (done) begin seen = 1; got = layer_output; end
                layer_input = 4'($urandom_range(15));
                act_mode    = 2'($urandom_range(3));
                @(negedge clk);
            end
            tests++;
            if (seen == 0 || got !== exp_out) begin fails++; $display("FAIL toggle_out: run %0d got %h (done %0d) want %h", r, got, seen, exp_out); end
        end
    endtask

    task automatic test_random();
        logic [15:0] out, exp_out; logic sat, exp_sat; int lat; logic [3:0] v; logic [1:0] m;
        for (int r = 0; r < 25; r++) begin
            if (r % 5 == 0) begin
                for (int i = 0; i < 4; i++)
                    for (int n = 0; n < 2; n++) w_ref[i][n] = int'($urandom_range(255)) - 128;
                for (int n = 0; n < 2; n++) b_ref[n] = int'($urandom_range(255)) - 128;
                load_params();
            end
            v = 4'($urandom_range(15));
            m = 2'($urandom_range(3));
            model(v, m, exp_out, exp_sat);
            run_layer(v, m, lat, out, sat);
            tests++;
            if (out !== exp_out || sat !== exp_sat || lat != 6) begin
                fails++;
                $display("FAIL random_run: run %0d vec %b mode %0d got %h sat %b lat %0d want %h sat %b lat 6",
                         r, v, m, out, sat, lat, exp_out, exp_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_leaky();
        test_modes();
        test_saturation();
        test_back_to_back();
        test_reset_mid_run();
        test_input_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
